// File: rtl/uart_cfg_pkg.sv
// uart_cfg_pkg
// Shared constants and types for the UART configuration sequencer:
//   - register-file addresses of the four frame-configuration fields
//   - register-file reset defaults (the shadows must match these)
//   - legal frame-length bounds
//   - sequencer state encoding
//   - field_address(): maps a field index 0..3 onto its register address
package uart_cfg_pkg;

  localparam logic [3:0] ADDR_PARITY       = 4'd9;
  localparam logic [3:0] ADDR_PARITY_TYPE  = 4'd10;
  localparam logic [3:0] ADDR_STOP_BITS    = 4'd11;
  localparam logic [3:0] ADDR_FRAME_LENGTH = 4'd12;

  localparam logic       RST_PARITY       = 1'b1;
  localparam logic       RST_PARITY_TYPE  = 1'b0;
  localparam logic       RST_STOP_BITS    = 1'b0;
  localparam logic [3:0] RST_FRAME_LENGTH = 4'd8;

  localparam logic [3:0] FRAME_LENGTH_MIN = 4'd5;
  localparam logic [3:0] FRAME_LENGTH_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_WRITE = 3'd2,
    ST_GAP   = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  // Field addresses are contiguous, so the index is simply an offset.
  function automatic logic [3:0] field_address(input logic [1:0] idx);
    return ADDR_PARITY + {2'b00, idx};
  endfunction

endpackage

// File: rtl/uart_cfg_ack_timer.sv
// uart_cfg_ack_timer
// Counts cycles spent waiting for a register-file acknowledge.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the count (asserted on the cycle that enters WRITE)
//   enable     : count this cycle (asserted in every WRITE cycle)
//   expired    : high during the TIMEOUT_CYCLES-th enabled cycle
module uart_cfg_ack_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [3:0] LAST_COUNT = 4'(TIMEOUT_CYCLES - 1);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 4'd0;
    end else if (enable) begin
      count_d = count_q + 4'd1;
    end
  end

  // The count holds the number of WRITE cycles already completed, so the
  // final permitted cycle is the one where it equals TIMEOUT_CYCLES-1.
  assign expired = enable && (count_q == LAST_COUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_cfg_sequencer.sv
// uart_cfg_sequencer
// On a start request, captures a frame configuration and writes each field
// (parity, parity_type, stop_bits, frame_length) into the UART register file,
// in address order, skipping fields whose value already matches the shadow
// copy unless force_all is set.
// Build option: UART_CFG_TIMEOUT_EN enables an acknowledge timeout that
// aborts the sequence with error after TIMEOUT_CYCLES WRITE cycles.
// Ports:
//   clk_16bd, rst_n        : 16x-baud clock, asynchronous active-low reset
//   start, force_all       : request pulse (IDLE only), write-all qualifier
//   cfg_*                  : requested field values
//   busy, done, error      : status (done is a 1-cycle pulse, error sticky)
//   rf_valid/address/data  : write port to register file; rf_ack returns
//   dbg_state              : current sequencer state
// Handshake: rf_valid rises on entry to WRITE and stays high, with address
// and data stable, until the cycle rf_ack is sampled high; it is then low
// for at least one cycle (GAP) before the next write.
module uart_cfg_sequencer
  import uart_cfg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       clk_16bd,
  input  logic       rst_n,
  input  logic       start,
  input  logic       force_all,
  input  logic       cfg_parity,
  input  logic       cfg_parity_type,
  input  logic       cfg_stop_bits,
  input  logic [3:0] cfg_frame_length,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       rf_valid,
  output logic [3:0] rf_address,
  output logic [3:0] rf_data,
  input  logic       rf_ack,
  output state_e     dbg_state
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 15) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..15");
  end

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       error_q, error_d;
  logic       valid_q, valid_d;
  logic [3:0] addr_q, addr_d;
  logic [3:0] data_q, data_d;
  logic       len_bad_q, len_bad_d;
  logic       lat_force_q, lat_force_d;
  logic       lat_parity_q, lat_parity_d;
  logic       lat_ptype_q, lat_ptype_d;
  logic       lat_stop_q, lat_stop_d;
  logic [3:0] lat_len_q, lat_len_d;
  logic       sh_parity_q, sh_parity_d;
  logic       sh_ptype_q, sh_ptype_d;
  logic       sh_stop_q, sh_stop_d;
  logic [3:0] sh_len_q, sh_len_d;

  logic [3:0] cur_val;
  logic [3:0] cur_shadow;
  logic       cur_dirty;
  logic       enter_write;
  logic       timer_expired;

  // Requested and shadow value of the field under the current index.
  always_comb begin
    cur_val    = 4'd0;
    cur_shadow = 4'd0;
    case (idx_q[1:0])
      2'd0: begin cur_val = {3'b000, lat_parity_q}; cur_shadow = {3'b000, sh_parity_q}; end
      2'd1: begin cur_val = {3'b000, lat_ptype_q};  cur_shadow = {3'b000, sh_ptype_q};  end
      2'd2: begin cur_val = {3'b000, lat_stop_q};   cur_shadow = {3'b000, sh_stop_q};   end
      default: begin cur_val = lat_len_q; cur_shadow = sh_len_q; end
    endcase
  end

  assign cur_dirty   = lat_force_q || (cur_val != cur_shadow);
  assign enter_write = (state_q == ST_SCAN) && !len_bad_q && cur_dirty;

`ifdef UART_CFG_TIMEOUT_EN
  uart_cfg_ack_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_ack_timer (
    .clk     (clk_16bd),
    .rst_n   (rst_n),
    .clear   (enter_write),
    .enable  (state_q == ST_WRITE),
    .expired (timer_expired)
  );
`else
  assign timer_expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    valid_d     = 1'b0;
    addr_d      = 4'd0;
    data_d      = 4'd0;
    len_bad_d   = len_bad_q;
    lat_force_d = lat_force_q;
    lat_parity_d = lat_parity_q;
    lat_ptype_d = lat_ptype_q;
    lat_stop_d  = lat_stop_q;
    lat_len_d   = lat_len_q;
    sh_parity_d = sh_parity_q;
    sh_ptype_d  = sh_ptype_q;
    sh_stop_d   = sh_stop_q;
    sh_len_d    = sh_len_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          lat_force_d  = force_all;
          lat_parity_d = cfg_parity;
          lat_ptype_d  = cfg_parity_type;
          lat_stop_d   = cfg_stop_bits;
          lat_len_d    = cfg_frame_length;
          len_bad_d    = (cfg_frame_length < FRAME_LENGTH_MIN) ||
                         (cfg_frame_length > FRAME_LENGTH_MAX);
          error_d      = 1'b0;
          idx_d        = 3'd0;
          busy_d       = 1'b1;
          state_d      = ST_SCAN;
        end
      end

      // A rejected request still spends its one SCAN cycle here, so done
      // and error for an illegal length land two cycles after start.
      ST_SCAN: begin
        if (len_bad_q) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = ST_FIN;
        end else if (cur_dirty) begin
          valid_d = 1'b1;
          addr_d  = field_address(idx_q[1:0]);
          data_d  = cur_val;
          state_d = ST_WRITE;
        end else begin
          idx_d = idx_q + 3'd1;
          if (idx_q[1:0] == 2'd3) begin
            done_d  = 1'b1;
            state_d = ST_FIN;
          end
        end
      end

      ST_WRITE: begin
        if (rf_ack) begin
          case (idx_q[1:0])
            2'd0:    sh_parity_d = lat_parity_q;
            2'd1:    sh_ptype_d  = lat_ptype_q;
            2'd2:    sh_stop_d   = lat_stop_q;
            default: sh_len_d    = lat_len_q;
          endcase
          idx_d   = idx_q + 3'd1;
          state_d = ST_GAP;
        end else if (timer_expired) begin
          // Shadow untouched: the register file never confirmed the write.
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = ST_FIN;
        end else begin
          valid_d = 1'b1;
          addr_d  = addr_q;
          data_d  = data_q;
        end
      end

      ST_GAP: begin
        if (idx_q[2]) begin
          done_d  = 1'b1;
          state_d = ST_FIN;
        end else begin
          state_d = ST_SCAN;
        end
      end

      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_16bd or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= 3'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      valid_q      <= 1'b0;
      addr_q       <= 4'd0;
      data_q       <= 4'd0;
      len_bad_q    <= 1'b0;
      lat_force_q  <= 1'b0;
      lat_parity_q <= 1'b0;
      lat_ptype_q  <= 1'b0;
      lat_stop_q   <= 1'b0;
      lat_len_q    <= 4'd0;
      sh_parity_q  <= RST_PARITY;
      sh_ptype_q   <= RST_PARITY_TYPE;
      sh_stop_q    <= RST_STOP_BITS;
      sh_len_q     <= RST_FRAME_LENGTH;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      len_bad_q    <= len_bad_d;
      lat_force_q  <= lat_force_d;
      lat_parity_q <= lat_parity_d;
      lat_ptype_q  <= lat_ptype_d;
      lat_stop_q   <= lat_stop_d;
      lat_len_q    <= lat_len_d;
      sh_parity_q  <= sh_parity_d;
      sh_ptype_q   <= sh_ptype_d;
      sh_stop_q    <= sh_stop_d;
      sh_len_q     <= sh_len_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign rf_valid   = valid_q;
  assign rf_address = addr_q;
  assign rf_data    = data_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_cfg_sequencer.sv
// tb_uart_cfg_sequencer
// Drives configuration requests, models the register file (acks on the
// second cycle of each write, optionally withholding one address) and
// scoreboards the expected writes, done latency and error flag.
module tb_uart_cfg_sequencer;
  import uart_cfg_pkg::*;

  localparam int TIMEOUT = 15;

  logic       clk_16bd = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       force_all = 1'b0;
  logic       cfg_parity = 1'b0;
  logic       cfg_parity_type = 1'b0;
  logic       cfg_stop_bits = 1'b0;
  logic [3:0] cfg_frame_length = 4'd0;
  logic       rf_ack = 1'b0;
  logic       busy, done, error, rf_valid;
  logic [3:0] rf_address, rf_data;
  state_e     dbg_state;

  uart_cfg_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_16bd         (clk_16bd),
    .rst_n            (rst_n),
    .start            (start),
    .force_all        (force_all),
    .cfg_parity       (cfg_parity),
    .cfg_parity_type  (cfg_parity_type),
    .cfg_stop_bits    (cfg_stop_bits),
    .cfg_frame_length (cfg_frame_length),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .rf_valid         (rf_valid),
    .rf_address       (rf_address),
    .rf_data          (rf_data),
    .rf_ack           (rf_ack),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk_16bd = ~clk_16bd;

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [7:0] exp_q[$];          // {address, data} of each expected write
  logic [3:0] m_sh[4] = '{4'd1, 4'd0, 4'd0, 4'd8};
  int         exp_done_k;
  logic       exp_err;
  logic [3:0] hold_addr = 4'd0;  // register-file model never acks this address
  int         n_writes_seen = 0;
  logic       skip_width = 1'b0;

  task automatic model_req(input logic f, input logic p, input logic pt,
                           input logic sb, input logic [3:0] len);
    logic [3:0] want[4];
    logic [3:0] addr;
    want[0] = {3'b000, p};
    want[1] = {3'b000, pt};
    want[2] = {3'b000, sb};
    want[3] = len;
    if (len < 4'd5 || len > 4'd9) begin
      exp_err    = 1'b1;
      exp_done_k = 2;
      return;
    end
    exp_err    = 1'b0;
    exp_done_k = 1;
    for (int i = 0; i < 4; i++) begin
      addr = 4'(9 + i);
      if (f || want[i] != m_sh[i]) begin
        exp_q.push_back({addr, want[i]});
        if (addr == hold_addr) begin
          exp_done_k += 1 + TIMEOUT;
          exp_err = 1'b1;
          return;
        end
        exp_done_k += 4;
        m_sh[i] = want[i];
      end else begin
        exp_done_k += 1;
      end
    end
  endtask

  // ---------------- monitor + register-file responder ----------------
  logic       prev_valid = 1'b0;
  int         vlen = 0;
  logic [3:0] last_addr = 4'd0;
  logic [3:0] last_data = 4'd0;

  always @(posedge clk_16bd) begin
    logic [7:0] e;
    #1;
    if (rf_valid && !prev_valid) begin
      n_writes_seen++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_write_addr", rf_address, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("wr_addr", rf_address, e[7:4]);
        check_eq("wr_data", rf_data, e[3:0]);
      end
    end
    if (rf_valid && prev_valid) begin
      check_eq("addr_stable", rf_address, last_addr);
      check_eq("data_stable", rf_data, last_data);
    end
    if (!rf_valid) begin
      check_eq("addr_idle_zero", rf_address, 0);
      check_eq("data_idle_zero", rf_data, 0);
    end
    if (rf_valid) begin
      vlen++;
    end else if (prev_valid) begin
      if (!skip_width) check_eq("valid_width", vlen, (last_addr == hold_addr) ? TIMEOUT : 2);
      vlen = 0;
    end
    rf_ack     = rf_valid && prev_valid && (rf_address != hold_addr);
    prev_valid = rf_valid;
    last_addr  = rf_address;
    last_data  = rf_data;
  end

  // ---------------- driver ----------------
  task automatic run_req(input logic f, input logic p, input logic pt,
                         input logic sb, input logic [3:0] len, input string tag);
    int k;
    model_req(f, p, pt, sb, len);
    @(negedge clk_16bd);
    force_all        = f;
    cfg_parity       = p;
    cfg_parity_type  = pt;
    cfg_stop_bits    = sb;
    cfg_frame_length = len;
    start            = 1'b1;
    @(negedge clk_16bd);
    start = 1'b0;
    k = 1;
    check_eq({tag, "_busy"}, busy, 1);
    while (!done && k < 80) begin
      @(negedge clk_16bd);
      k++;
    end
    check_eq({tag, "_done_cycle"}, k, exp_done_k);
    check_eq({tag, "_error"}, error, exp_err);
    @(negedge clk_16bd);
    check_eq({tag, "_done_pulse"}, done, 0);
    check_eq({tag, "_busy_after"}, busy, 0);
    check_eq({tag, "_error_sticky"}, error, exp_err);
    check_eq({tag, "_writes_pending"}, exp_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_error"}, error, 0);
    check_eq({tag, "_valid"}, rf_valid, 0);
    check_eq({tag, "_addr"}, rf_address, 0);
    check_eq({tag, "_data"}, rf_data, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    int k;
    logic [3:0] rlen;
    logic       sb_flip;

    repeat (3) @(negedge clk_16bd);
    check_outputs_zero("in_reset");
    rst_n = 1'b1;
    @(negedge clk_16bd);
    check_outputs_zero("after_reset");

    run_req(1'b0, 1'b1, 1'b0, 1'b0, 4'd8, "nodirty");
    run_req(1'b1, 1'b1, 1'b0, 1'b0, 4'd8, "force_all");
    run_req(1'b0, 1'b1, 1'b1, 1'b0, 4'd7, "pt_len");
    run_req(1'b0, 1'b1, 1'b1, 1'b0, 4'd7, "repeat");
    run_req(1'b0, 1'b1, 1'b1, 1'b0, 4'd4, "len4");
    run_req(1'b0, 1'b0, 1'b0, 1'b1, 4'd10, "len10");
    run_req(1'b0, 1'b1, 1'b1, 1'b0, 4'd7, "clear_err");

    for (int i = 0; i < 8; i++) begin
      rlen = 4'($urandom_range(5, 9));
      run_req(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rlen, "rand");
    end

`ifdef UART_CFG_TIMEOUT_EN
    hold_addr = ADDR_STOP_BITS;
    sb_flip   = ~m_sh[2][0];
    run_req(1'b0, 1'b1, 1'b0, sb_flip, 4'd6, "timeout");
    hold_addr = 4'd0;
    run_req(1'b0, 1'b1, 1'b0, sb_flip, 4'd6, "after_timeout");
`else
    sb_flip = 1'b0;
`endif

    // Reset during the second write of a forced sequence.
    model_req(1'b1, 1'b1, 1'b0, sb_flip, 4'd8);
    base = n_writes_seen;
    @(negedge clk_16bd);
    force_all        = 1'b1;
    cfg_parity       = 1'b1;
    cfg_parity_type  = 1'b0;
    cfg_stop_bits    = sb_flip;
    cfg_frame_length = 4'd8;
    start            = 1'b1;
    @(negedge clk_16bd);
    start = 1'b0;
    k = 0;
    while (n_writes_seen - base < 2 && k < 40) begin
      @(negedge clk_16bd);
      k++;
    end
    check_eq("rst_reach_second_write", n_writes_seen - base, 2);
    skip_width = 1'b1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    exp_q.delete();
    m_sh = '{4'd1, 4'd0, 4'd0, 4'd8};
    @(negedge clk_16bd);
    rst_n = 1'b1;
    @(negedge clk_16bd);
    @(negedge clk_16bd);
    skip_width = 1'b0;
    run_req(1'b1, 1'b1, 1'b0, 1'b0, 4'd8, "post_reset_force");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cfg_sequencer.md
# uart_cfg_sequencer

Configuration sequencer for the UART register file. On a single `start` request it captures a complete frame configuration and writes each field into the register file over its `valid/address/data/ack` port, one register at a time. By default it writes only the fields whose value differs from its shadow copy. It reports completion with `done`, and `error` on a bad request or a missing acknowledge. It sits between host/menu control logic and the UART register file, in the 16×-baud clock domain.

## Interface
- `TIMEOUT_CYCLES`, 15, cycles spent in WRITE without `rf_ack` before aborting; range 2..15.
- `clk_16bd`  in  1  16×-baud clock; one clock; reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `force_all`  in  1  sampled with `start`; 1 = write all four fields regardless of shadow.
- `cfg_parity`, `cfg_parity_type`, `cfg_stop_bits`  in  1 each  requested field values.
- `cfg_frame_length`  in  4  requested data bits; legal values 5..9.
- `busy`  out  1  high from the cycle after an accepted `start` through FIN.
- `done`  out  1  one-cycle pulse in FIN.
- `error`  out  1  sticky; cleared by the next accepted `start`.
- `rf_valid`  out  1  write strobe to the register file.
- `rf_address`  out  4  9 parity, 10 parity_type, 11 stop_bits, 12 frame_length.
- `rf_data`  out  4  field value; 1-bit fields are zero-extended.
- `rf_ack`  in  1  one-cycle acknowledge from the register file.

## Operation
- Shadow reset values mirror the register-file defaults: parity=1, parity_type=0, stop_bits=0, frame_length=8.
- IDLE: on `start`, latch all `cfg_*` inputs and `force_all`, clear `error`, set field index to 0.
  - If `cfg_frame_length` is outside 5..9: set `error`, perform no writes, go to FIN.
  - Otherwise go to SCAN.
- `start` outside IDLE is ignored.
- SCAN (1 cycle): index 4 → FIN. Field dirty (latched value differs from shadow, or `force_all` set) → WRITE. Clean → index+1, remain in SCAN.
- WRITE: `rf_valid`=1, with address and data taken from the index.
  - On `rf_ack`: update that field's shadow, index+1, go to GAP.
- GAP (1 cycle): `rf_valid`=0 so the register file re-arms; then go to SCAN.
- FIN (1 cycle): `done`=1; next state IDLE.
- Fields are always written in address order 9, 10, 11, 12.
- `rf_valid` is a pure state decode: high only in WRITE. `rf_address`/`rf_data` hold stable throughout WRITE and read 0 outside it.
- An `rf_ack` arriving outside WRITE is ignored.

## Timing
- Reset values: `busy`=0, `done`=0, `error`=0, `rf_valid`=0, `rf_address`=0, `rf_data`=0. State is IDLE and shadows hold their defaults.
- Edge N samples `start`. SCAN is cycle N+1. A dirty field 0 puts `rf_valid` high in N+2.
- The register file acks at N+3. `rf_valid` drops at N+4 (GAP), so `rf_valid` is high for exactly 2 cycles per write.
- Cost per dirty field: 4 cycles (SCAN, WRITE×2, GAP). Cost per clean field: 1 cycle.
- All four fields dirty: `done` in cycle N+17. No fields dirty: `done` in N+5. Illegal length: `done` and `error` in N+2.
- `rst_n` asserted mid-sequence: immediate return to the reset state, and shadows revert to defaults. This is consistent because the register file shares the same reset.

## Configuration
- `UART_CFG_TIMEOUT_EN` defined: an ack timer clears on entry to WRITE and counts each WRITE cycle.
  - At `TIMEOUT_CYCLES` without `rf_ack`: set `error`, leave the shadow unchanged, skip the remaining fields, drop `rf_valid`, go to FIN.
- `UART_CFG_TIMEOUT_EN` undefined: no timer; WRITE waits indefinitely for `rf_ack`. `error` is raised only by an illegal frame length.

## Structure
- Package `uart_cfg_pkg` holds:
  - the address constants (9..12);
  - the reset-default constants (shared with the register file);
  - the state encoding IDLE/SCAN/WRITE/GAP/FIN;
  - the legal frame-length bounds (5, 9).
- Sub-module `uart_cfg_ack_timer` (clear, enable, expired) holds the timeout counter. It is instantiated only under `UART_CFG_TIMEOUT_EN`.

## Test plan
- After reset, `start` with parity=1, type=0, stop=0, len=8, `force_all`=0 → no `rf_valid`; `done` at N+5; `error`=0.
- `start` with `force_all`=1 and defaults → 4 writes (addr 9,10,11,12; data 1,0,0,8); each `rf_valid` 2 cycles wide; `done` at N+17.
- `start` with parity_type=1, len=7 → writes addr 10 data 1, then addr 12 data 7 only. Repeating the same request produces zero writes.
- `start` with len=4, then len=10 → `error`=1 and `done` at N+2, no writes. A following legal `start` clears `error`.
- With `UART_CFG_TIMEOUT_EN`: register-file model withholds `rf_ack` for addr 11 → `error` set after 15 WRITE cycles, addr 12 not written, addr 11 shadow unchanged.
- `rst_n` pulsed low during the second WRITE → all outputs 0 immediately. A subsequent `force_all` request rewrites all 4 fields.
